// File: rtl/mac_accumulator.sv
// mac_accumulator
// Saturating accumulator for a run of unsigned product samples from an
// upstream multiplier. A run starts in IDLE on start, accepts exactly len
// samples (len = 0 means 2^CNT_WIDTH samples), then holds the result until
// the downstream side accepts it.
//
// Ports
//   sys_clk       rising-edge clock
//   sys_reset     asynchronous active-low reset
//   start         begin a run (sampled only in IDLE)
//   len           sample count for the run, latched on start
//   in_product    unsigned product sample
//   in_valid      in_product valid
//   in_ready      sample accepted this cycle when in_valid is also high
//   out_acc       accumulated result (kept in IDLE until the next start)
//   out_valid     result valid (DONE)
//   out_ready     downstream accepts the result
//   out_overflow  result saturated during this run
//   busy          run in progress or result pending
//
// state | meaning
// IDLE  | waiting for start; last result still visible on out_acc
// ACCUM | accepting samples until the latched count is reached
// DONE  | result presented, waiting for out_ready
module mac_accumulator #(
   parameter int PROD_WIDTH = 16,
   parameter int ACC_WIDTH  = 24,
   parameter int CNT_WIDTH  = 4
) (
   input  logic                  sys_clk,
   input  logic                  sys_reset,
   input  logic                  start,
   input  logic [CNT_WIDTH-1:0]  len,
   input  logic [PROD_WIDTH-1:0] in_product,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [ACC_WIDTH-1:0]  out_acc,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_overflow,
   output logic                  busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t               state;
   logic [ACC_WIDTH-1:0] acc;
   logic                 ovf;
   // One extra bit so that len = 0 can be stored as 2^CNT_WIDTH.
   logic [CNT_WIDTH:0]   cnt;
   logic [CNT_WIDTH:0]   len_q;
   logic [CNT_WIDTH:0]   cnt_nxt;
   logic [CNT_WIDTH:0]   len_ext;
   logic [ACC_WIDTH:0]   sum;
   logic                 accept;

   assign in_ready     = (state == ACCUM);
   assign out_valid    = (state == DONE);
   assign busy         = (state != IDLE);
   assign out_acc      = acc;
   assign out_overflow = ovf;

   assign accept  = in_ready & in_valid;
   assign cnt_nxt = cnt + {{CNT_WIDTH{1'b0}}, 1'b1};
   assign len_ext = (len == '0) ? {1'b1, {CNT_WIDTH{1'b0}}} : {1'b0, len};
   // Carry-out of the widened sum flags overflow of the accumulator.
   assign sum     = {1'b0, acc} + {{(ACC_WIDTH + 1 - PROD_WIDTH){1'b0}}, in_product};

   always_ff @(posedge sys_clk or negedge sys_reset) begin
      if (!sys_reset) begin
         state <= IDLE;
         acc   <= '0;
         ovf   <= 1'b0;
         cnt   <= '0;
         len_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  acc   <= '0;
                  ovf   <= 1'b0;
                  cnt   <= '0;
                  len_q <= len_ext;
                  state <= ACCUM;
               end
            end
            ACCUM: begin
               if (accept) begin
                  cnt <= cnt_nxt;
                  // Once saturated, stay saturated for the rest of the run.
                  if (ovf || sum[ACC_WIDTH]) begin
                     acc <= '1;
                     ovf <= 1'b1;
                  end else begin
                     acc <= sum[ACC_WIDTH-1:0];
                  end
                  if (cnt_nxt == len_q) begin
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: expected results are computed by a small
// saturating-add model, pushed to a queue when a run is driven, and popped
// when the DUT presents out_valid. Inputs change on the falling edge and
// outputs are checked on the falling edge.
module tb_mac_accumulator;

   localparam int PW = 16;
   localparam int AW = 20;
   localparam int AW_SAT = 17;
   localparam int CW = 4;

   logic          sys_clk;
   logic          sys_reset;
   logic          start;
   logic [CW-1:0] len;
   logic [PW-1:0] in_product;
   logic          in_valid;
   logic          in_ready;
   logic [AW-1:0] out_acc;
   logic          out_valid;
   logic          out_ready;
   logic          out_overflow;
   logic          busy;

   logic              sat_in_ready;
   logic [AW_SAT-1:0] sat_out_acc;
   logic              sat_out_valid;
   logic              sat_out_overflow;
   logic              sat_busy;

   typedef struct {
      logic [31:0] acc;
      logic        ovf;
   } res_t;

   res_t sb[$];
   res_t sb_sat[$];

   int n_checks = 0;
   int n_fail   = 0;

   mac_accumulator #(.PROD_WIDTH(PW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
      .sys_clk      (sys_clk),
      .sys_reset    (sys_reset),
      .start        (start),
      .len          (len),
      .in_product   (in_product),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .out_acc      (out_acc),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_overflow (out_overflow),
      .busy         (busy)
   );

   // Narrow accumulator sharing the same stimulus: 16 x 0xFFFF fits in 20
   // bits, so saturation is exercised on a 17-bit accumulator.
   mac_accumulator #(.PROD_WIDTH(PW), .ACC_WIDTH(AW_SAT), .CNT_WIDTH(CW)) dut_sat (
      .sys_clk      (sys_clk),
      .sys_reset    (sys_reset),
      .start        (start),
      .len          (len),
      .in_product   (in_product),
      .in_valid     (in_valid),
      .in_ready     (sat_in_ready),
      .out_acc      (sat_out_acc),
      .out_valid    (sat_out_valid),
      .out_ready    (out_ready),
      .out_overflow (sat_out_overflow),
      .busy         (sat_busy)
   );

   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish within time limit");
      $fatal(1, "watchdog");
   end

   function automatic res_t model_add(input res_t r, input logic [31:0] p, input int w);
      logic [32:0] s;
      logic [32:0] lim;
      res_t        o;
      lim = (33'd1 << w) - 33'd1;
      s   = {1'b0, r.acc} + {1'b0, p};
      o.ovf = r.ovf;
      if (r.ovf || s > lim) begin
         o.acc = lim[31:0];
         o.ovf = 1'b1;
      end else begin
         o.acc = s[31:0];
      end
      return o;
   endfunction

   // Stimulus helpers (called at a falling edge, return at a falling edge).
   task automatic do_start(input logic [CW-1:0] l);
      start = 1'b1;
      len   = l;
      @(negedge sys_clk);
      start = 1'b0;
   endtask

   task automatic send(input logic [PW-1:0] p);
      in_valid   = 1'b1;
      in_product = p;
      @(negedge sys_clk);
      in_valid   = 1'b0;
   endtask

   task automatic test_reset;
      res_t e;
      sys_reset = 1'b0;
      #3;
      n_checks++;
      if (out_acc !== '0 || out_valid !== 1'b0 || out_overflow !== 1'b0 ||
          in_ready !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got acc=%h v=%b ovf=%b rdy=%b busy=%b, want all 0",
                  out_acc, out_valid, out_overflow, in_ready, busy);
      end
      @(negedge sys_clk);
      @(negedge sys_clk);
      sys_reset = 1'b1;
      @(negedge sys_clk);
      n_checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle: got busy=%b v=%b, want 0 0", busy, out_valid);
      end
      e.acc = 0;
      e.ovf = 0;
      e = e;
   endtask

   task automatic test_basic;
      res_t e;
      logic [PW-1:0] s [3];
      s[0] = 16'd10; s[1] = 16'd20; s[2] = 16'd30;
      out_ready = 1'b1;
      do_start(4'd3);
      n_checks++;
      if (in_ready !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_accum_state: got rdy=%b busy=%b v=%b, want 1 1 0",
                  in_ready, busy, out_valid);
      end
      e.acc = 0; e.ovf = 0;
      for (int i = 0; i < 3; i++) e = model_add(e, {16'd0, s[i]}, AW);
      sb.push_back(e);
      for (int i = 0; i < 3; i++) send(s[i]);
      n_checks++;
      if (out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_latency: got out_valid=%b one cycle after final accept, want 1", out_valid);
      end else begin
         e = sb.pop_front();
         n_checks++;
         if (out_acc !== e.acc[AW-1:0] || out_overflow !== e.ovf) begin
            n_fail++;
            $display("FAIL basic_result: got acc=%0d ovf=%b, want acc=%0d ovf=%b",
                     out_acc, out_overflow, e.acc, e.ovf);
         end
      end
      @(negedge sys_clk);
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || out_acc !== 20'd60) begin
         n_fail++;
         $display("FAIL basic_pulse: got v=%b busy=%b acc=%0d, want 0 0 60",
                  out_valid, busy, out_acc);
      end
   endtask

   task automatic test_gaps;
      res_t e;
      out_ready = 1'b1;
      do_start(4'd2);
      e.acc = 0; e.ovf = 0;
      e = model_add(e, 32'h0000FFFF, AW);
      e = model_add(e, 32'h00000001, AW);
      sb.push_back(e);
      send(16'hFFFF);
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_ready: cycle %0d got rdy=%b v=%b, want 1 0", i, in_ready, out_valid);
         end
         @(negedge sys_clk);
      end
      send(16'h0001);
      n_checks++;
      if (out_valid !== 1'b1 || sb.size() == 0) begin
         n_fail++;
         $display("FAIL gap_valid: got out_valid=%b, want 1", out_valid);
      end else begin
         e = sb.pop_front();
         n_checks++;
         if (out_acc !== e.acc[AW-1:0] || out_overflow !== e.ovf) begin
            n_fail++;
            $display("FAIL gap_result: got acc=%h ovf=%b, want acc=%h ovf=%b",
                     out_acc, out_overflow, e.acc, e.ovf);
         end
      end
      @(negedge sys_clk);
   endtask

   task automatic test_overflow;
      res_t e;
      res_t es;
      out_ready = 1'b1;
      do_start(4'd0);
      e.acc = 0; e.ovf = 0;
      es.acc = 0; es.ovf = 0;
      for (int i = 0; i < 16; i++) begin
         e  = model_add(e, 32'h0000FFFF, AW);
         es = model_add(es, 32'h0000FFFF, AW_SAT);
      end
      sb.push_back(e);
      sb_sat.push_back(es);
      for (int i = 0; i < 15; i++) send(16'hFFFF);
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL len0_count: after 15 samples got v=%b rdy=%b, want 0 1", out_valid, in_ready);
      end
      send(16'hFFFF);
      n_checks++;
      if (out_valid !== 1'b1 || sat_out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL len0_done: got v=%b sat_v=%b after 16 samples, want 1 1", out_valid, sat_out_valid);
      end else begin
         e  = sb.pop_front();
         es = sb_sat.pop_front();
         n_checks++;
         if (out_acc !== e.acc[AW-1:0] || out_overflow !== e.ovf) begin
            n_fail++;
            $display("FAIL len0_result: got acc=%h ovf=%b, want acc=%h ovf=%b",
                     out_acc, out_overflow, e.acc, e.ovf);
         end
         n_checks++;
         if (sat_out_acc !== es.acc[AW_SAT-1:0] || sat_out_overflow !== es.ovf ||
             sat_out_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL saturate_result: got acc=%h ovf=%b, want acc=%h ovf=1",
                     sat_out_acc, sat_out_overflow, es.acc);
         end
      end
      @(negedge sys_clk);
   endtask

   task automatic test_hold;
      res_t e;
      out_ready = 1'b0;
      do_start(4'd1);
      e.acc = 0; e.ovf = 0;
      e = model_add(e, 32'd5, AW);
      sb.push_back(e);
      send(16'd5);
      e = sb.pop_front();
      for (int i = 0; i < 5; i++) begin
         start = i[0] ? 1'b0 : 1'b1;
         len   = 4'd3;
         n_checks++;
         if (out_valid !== 1'b1 || out_acc !== e.acc[AW-1:0] || in_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_stable: cycle %0d got v=%b acc=%0d rdy=%b busy=%b, want 1 %0d 0 1",
                     i, out_valid, out_acc, in_ready, busy, e.acc);
         end
         @(negedge sys_clk);
      end
      start     = 1'b1;
      out_ready = 1'b1;
      @(negedge sys_clk);
      start = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || out_acc !== e.acc[AW-1:0]) begin
         n_fail++;
         $display("FAIL hold_release: got v=%b busy=%b acc=%0d, want 0 0 %0d",
                  out_valid, busy, out_acc, e.acc);
      end
      @(negedge sys_clk);
      n_checks++;
      if (busy !== 1'b0 || out_acc !== e.acc[AW-1:0]) begin
         n_fail++;
         $display("FAIL idle_retain: got busy=%b acc=%0d, want 0 %0d", busy, out_acc, e.acc);
      end
   endtask

   task automatic test_reset_mid_run;
      res_t e;
      out_ready = 1'b1;
      do_start(4'd4);
      send(16'd100);
      send(16'd200);
      #2;
      sys_reset = 1'b0;
      #1;
      n_checks++;
      if (out_acc !== '0 || out_valid !== 1'b0 || out_overflow !== 1'b0 ||
          in_ready !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_async: got acc=%h v=%b ovf=%b rdy=%b busy=%b, want all 0",
                  out_acc, out_valid, out_overflow, in_ready, busy);
      end
      @(negedge sys_clk);
      sys_reset = 1'b1;
      @(negedge sys_clk);
      do_start(4'd1);
      e.acc = 0; e.ovf = 0;
      e = model_add(e, 32'd7, AW);
      sb.push_back(e);
      send(16'd7);
      n_checks++;
      if (out_valid !== 1'b1 || sb.size() == 0) begin
         n_fail++;
         $display("FAIL post_reset_valid: got out_valid=%b, want 1", out_valid);
      end else begin
         e = sb.pop_front();
         n_checks++;
         if (out_acc !== e.acc[AW-1:0] || out_overflow !== e.ovf) begin
            n_fail++;
            $display("FAIL post_reset_result: got acc=%0d ovf=%b, want acc=%0d ovf=%b",
                     out_acc, out_overflow, e.acc, e.ovf);
         end
      end
      @(negedge sys_clk);
   endtask

   task automatic test_len_change;
      res_t e;
      out_ready = 1'b1;
      do_start(4'd2);
      len = 4'd5;
      e.acc = 0; e.ovf = 0;
      e = model_add(e, 32'd111, AW);
      e = model_add(e, 32'd222, AW);
      sb.push_back(e);
      send(16'd111);
      send(16'd222);
      n_checks++;
      if (out_valid !== 1'b1 || sb.size() == 0) begin
         n_fail++;
         $display("FAIL len_latched: got out_valid=%b after 2 samples, want 1", out_valid);
      end else begin
         e = sb.pop_front();
         n_checks++;
         if (out_acc !== e.acc[AW-1:0]) begin
            n_fail++;
            $display("FAIL len_latched_result: got acc=%0d, want %0d", out_acc, e.acc);
         end
      end
      @(negedge sys_clk);
   endtask

   task automatic test_back_to_back;
      res_t e;
      out_ready = 1'b1;
      for (int r = 0; r < 3; r++) begin
         do_start(4'(r + 2));
         e.acc = 0; e.ovf = 0;
         for (int i = 0; i < r + 2; i++) e = model_add(e, 32'(1000 * (r + 1) + i), AW);
         sb.push_back(e);
         for (int i = 0; i < r + 2; i++) send(16'(1000 * (r + 1) + i));
         n_checks++;
         if (out_valid !== 1'b1 || sb.size() == 0) begin
            n_fail++;
            $display("FAIL b2b_valid: run %0d got out_valid=%b, want 1", r, out_valid);
         end else begin
            e = sb.pop_front();
            n_checks++;
            if (out_acc !== e.acc[AW-1:0] || out_overflow !== e.ovf) begin
               n_fail++;
               $display("FAIL b2b_result: run %0d got acc=%0d ovf=%b, want acc=%0d ovf=%b",
                        r, out_acc, out_overflow, e.acc, e.ovf);
            end
         end
         @(negedge sys_clk);
      end
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_empty: %0d results outstanding, want 0", sb.size());
      end
   endtask

   initial begin
      sys_reset  = 1'b0;
      start      = 1'b0;
      len        = '0;
      in_product = '0;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      test_reset();
      test_basic();
      test_gaps();
      test_overflow();
      test_hold();
      test_reset_mid_run();
      test_len_change();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
